// File: rtl/restador_pkg.sv
// Shared constants and a reference subtraction for the registered restador.
package restador_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Returns {cout, s} of a + ~b + 1 at DEFAULT_WIDTH+1 bits.
  function automatic logic [DEFAULT_WIDTH:0] ref_sub(input logic [DEFAULT_WIDTH-1:0] a,
                                                     input logic [DEFAULT_WIDTH-1:0] b);
    logic [DEFAULT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, ~b} + {{DEFAULT_WIDTH{1'b0}}, 1'b1};
    return sum;
  endfunction

endpackage

// File: rtl/sumador_completo.sv
// One-bit full adder used as a ripple-chain stage.
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/restador_4bit.sv
// Registered unsigned subtractor: {Cout, S} <= A + ~B + 1, one cycle latency.
module restador_4bit
  import restador_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;

  assign b_inv    = ~B;
  // Carry-in of 1 completes the two's-complement negation of B.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    sumador_completo u_fa (
      .a    (A[i]),
      .b    (b_inv[i]),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= diff;
      Cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_restador_4bit.sv
// Directed and randomized checks of restador_4bit against an arithmetic model.
module tb_restador_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [3:0] S;
  logic       Cout;

  int total = 0;
  int bad = 0;

  restador_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  // Model: difference modulo 16, no-borrow flag when minuend >= subtrahend.
  function automatic logic [4:0] model(input int a, input int b);
    int d;
    logic [4:0] r;
    d = (a - b + 16) % 16;
    r[3:0] = d[3:0];
    r[4] = (a >= b);
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] s_exp, input logic c_exp);
    total++;
    assert (S === s_exp) else begin
      bad++;
      $error("FAIL %s S: got %0d expected %0d", tag, S, s_exp);
    end
    total++;
    assert (Cout === c_exp) else begin
      bad++;
      $error("FAIL %s Cout: got %0b expected %0b", tag, Cout, c_exp);
    end
  endtask

  // Drive operands between edges, then sample 1 time unit after the capturing edge.
  task automatic op(input string tag, input int a, input int b);
    logic [4:0] e;
    A = 4'(a);
    B = 4'(b);
    e = model(a, b);
    @(posedge clk);
    #1;
    check(tag, e[3:0], e[4]);
  endtask

  initial begin
    logic [4:0] e;
    logic [4:0] q[$];

    // Reset held with operands present.
    A = 4'd9;
    B = 4'd2;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_hold", 4'd0, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release", 4'd7, 1'b1);

    op("a15_b11", 15, 11);
    op("a3_b5", 3, 5);
    op("a7_b7", 7, 7);
    op("a0_b15", 0, 15);
    op("b_zero", 10, 0);
    op("zero_minus_one", 0, 1);

    // Back-to-back random stream; a queue keeps results in order.
    for (int i = 0; i < 40; i++) begin
      A = 4'($urandom_range(0, 15));
      B = 4'($urandom_range(0, 15));
      q.push_back(model(int'(A), int'(B)));
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("stream", e[3:0], e[4]);
    end

    // Mid-operation reset pulse between edges discards the pending result.
    op("pre_pulse", 12, 4);
    A = 4'd5;
    B = 4'd9;
    #2 rst_n = 1'b0;
    #1 check("pulse_async", 4'd0, 1'b0);
    #1 rst_n = 1'b1;
    #1 check("pulse_released", 4'd0, 1'b0);
    @(posedge clk);
    #1 check("after_pulse", 4'd12, 1'b0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op("sweep", a, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
